// File: rtl/icache_assoc_param_if.sv
// Fetch, invalidate, memory-burst and performance-counter signals of the
// set-associative instruction cache, grouped for the cache and its environment.
interface icache_assoc_param_if;
    logic        from_cpu_inst_req_valid;
    logic [31:0] from_cpu_inst_req_addr;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready;
    logic        inv_req_valid;
    logic        inv_req_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;

    modport slave (
        input  from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
        input  inv_req_valid, from_mem_rd_req_ready, from_mem_rd_rsp_valid,
        input  from_mem_rd_rsp_data, from_mem_rd_rsp_last,
        output to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
        output inv_req_ready, to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready,
        output perf_hit_cnt, perf_miss_cnt
    );

    modport master (
        output from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
        output inv_req_valid, from_mem_rd_req_ready, from_mem_rd_rsp_valid,
        output from_mem_rd_rsp_data, from_mem_rd_rsp_last,
        input  to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
        input  inv_req_ready, to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready,
        input  perf_hit_cnt, perf_miss_cnt
    );
endinterface

// File: rtl/icache_assoc_param.sv
// Parametrised N-way set-associative read-only instruction cache with
// tree-PLRU replacement, whole-cache invalidate and hit/miss counters.
module icache_assoc_param #(
    parameter int NUM_SET    = 8,
    parameter int NUM_WAY    = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    icache_assoc_param_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(NUM_SET);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WAY_W  = $clog2(NUM_WAY);
    localparam int WRD_W  = $clog2(LINE_WORDS);
    localparam int PLRU_W = NUM_WAY - 1;
    localparam logic [WRD_W:0]   BEAT_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SET - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_TAG_RD, S_HIT_RD, S_EVICT, S_MEM_REQ, S_RECV, S_REFILL, S_RESP, S_INV
    } state_t;

    state_t              r_state;
    logic [31:2]         r_addr;
    logic [NUM_WAY-1:0]  r_valid [NUM_SET];
    logic [TAG_W-1:0]    r_tag   [NUM_SET][NUM_WAY];
    logic [31:0]         r_data  [NUM_SET][NUM_WAY][LINE_WORDS];
    logic [PLRU_W-1:0]   r_plru  [NUM_SET];
    logic [31:0]         r_buf   [LINE_WORDS];
    logic [WAY_W-1:0]    r_way;
    logic [WRD_W:0]      r_beat;
    logic [IDX_W-1:0]    r_inv_idx;
    logic [31:0]         r_hit_cnt, r_miss_cnt, r_rsp_data;
    logic                r_req_ready, r_inv_ready, r_rsp_valid, r_mem_req_valid, r_mem_rsp_ready;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WRD_W-1:0]    w_off;
    logic [NUM_WAY-1:0]  w_match;
    logic [NUM_WAY-1:0]  w_invalid;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way, w_victim;

    function automatic logic [WAY_W-1:0] lowest_set(input logic [NUM_WAY-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = NUM_WAY - 1; i >= 0; i--) begin
            if (v[i]) r = WAY_W'(i);
        end
        return r;
    endfunction

    // Walk the tree from the root; a node bit of 1 sends the victim to the upper half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
        logic [WAY_W-1:0] w;
        logic             b;
        int               n;
        w = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = p[n];
            w = (w << 1) | WAY_W'(b);
            n = 2 * n + 1 + int'(b);
        end
        return w;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                      input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] q;
        logic              b;
        int                n;
        q = p;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b    = way[WAY_W-1-l];
            q[n] = ~b;
            n    = 2 * n + 1 + int'(b);
        end
        return q;
    endfunction

    assign w_idx = r_addr[OFF_W +: IDX_W];
    assign w_tag = r_addr[31 -: TAG_W];
    assign w_off = r_addr[2 +: WRD_W];

    // Tag compare across the indexed set and victim choice.
    always_comb begin
        for (int w = 0; w < NUM_WAY; w++) begin
            w_match[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
        end
        w_invalid = ~r_valid[w_idx];
        w_hit     = |w_match;
        w_hit_way = lowest_set(w_match);
        w_victim  = (|w_invalid) ? lowest_set(w_invalid) : plru_victim(r_plru[w_idx]);
    end

    // Control FSM, valid/PLRU state, counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_way           <= '0;
            r_beat          <= '0;
            r_inv_idx       <= '0;
            r_hit_cnt       <= 32'd0;
            r_miss_cnt      <= 32'd0;
            r_rsp_data      <= 32'd0;
            r_req_ready     <= 1'b1;
            r_inv_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_rsp_ready <= 1'b0;
            for (int s = 0; s < NUM_SET; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.inv_req_valid) begin
                        r_state     <= S_INV;
                        r_inv_idx   <= '0;
                        r_req_ready <= 1'b0;
                        r_inv_ready <= 1'b0;
                    end else if (bus.from_cpu_inst_req_valid) begin
                        r_state     <= S_TAG_RD;
                        r_addr      <= bus.from_cpu_inst_req_addr[31:2];
                        r_req_ready <= 1'b0;
                        r_inv_ready <= 1'b0;
                    end
                end
                S_TAG_RD: begin
                    if (w_hit) begin
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                        r_way     <= w_hit_way;
                        r_state   <= S_HIT_RD;
                    end else begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_state    <= S_EVICT;
                    end
                end
                S_HIT_RD: begin
                    r_rsp_data  <= r_data[w_idx][r_way][w_off];
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_EVICT: begin
                    r_way           <= w_victim;
                    r_beat          <= '0;
                    r_mem_req_valid <= 1'b1;
                    r_state         <= S_MEM_REQ;
                end
                S_MEM_REQ: begin
                    if (bus.from_mem_rd_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_rsp_ready <= 1'b1;
                        r_state         <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (bus.from_mem_rd_rsp_valid) begin
                        if (!r_beat[WRD_W]) r_beat <= r_beat + BEAT_ONE;
                        if (bus.from_mem_rd_rsp_last) begin
                            r_mem_rsp_ready <= 1'b0;
                            r_state         <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    r_valid[w_idx][r_way] <= 1'b1;
                    r_rsp_data            <= r_buf[w_off];
                    r_rsp_valid           <= 1'b1;
                    r_state               <= S_RESP;
                end
                S_RESP: begin
                    if (bus.from_cpu_cache_rsp_ready) begin
                        r_plru[w_idx] <= plru_touch(r_plru[w_idx], r_way);
                        r_rsp_valid   <= 1'b0;
                        r_req_ready   <= 1'b1;
                        r_inv_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_INV: begin
                    r_valid[r_inv_idx] <= '0;
                    r_plru[r_inv_idx]  <= '0;
                    r_inv_idx          <= r_inv_idx + IDX_ONE;
                    if (r_inv_idx == IDX_LAST) begin
                        r_req_ready <= 1'b1;
                        r_inv_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_req_ready     <= 1'b1;
                    r_inv_ready     <= 1'b1;
                    r_rsp_valid     <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                    r_mem_rsp_ready <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

    // Line buffer capture and line write; rst suppresses both so an aborted refill leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_RECV && bus.from_mem_rd_rsp_valid && !r_beat[WRD_W]) begin
            r_buf[r_beat[WRD_W-1:0]] <= bus.from_mem_rd_rsp_data;
        end
        if (!rst && r_state == S_REFILL) begin
            r_tag[w_idx][r_way] <= w_tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_data[w_idx][r_way][k] <= r_buf[k];
            end
        end
    end

    // While rst is high every output reads 0 except the beat-ready, which drains stale beats.
    assign bus.to_cpu_inst_req_ready  = r_req_ready & ~rst;
    assign bus.inv_req_ready          = r_inv_ready & ~rst;
    assign bus.to_cpu_cache_rsp_valid = r_rsp_valid & ~rst;
    assign bus.to_cpu_cache_rsp_data  = rst ? 32'd0 : r_rsp_data;
    assign bus.to_mem_rd_req_valid    = r_mem_req_valid & ~rst;
    assign bus.to_mem_rd_req_addr     = rst ? 32'd0 : {r_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign bus.to_mem_rd_rsp_ready    = r_mem_rsp_ready | rst;
    assign bus.perf_hit_cnt           = rst ? 32'd0 : r_hit_cnt;
    assign bus.perf_miss_cnt          = rst ? 32'd0 : r_miss_cnt;
endmodule
